// File: rtl/uart_pkg.sv
// Shared types and widths for the RS485 frame scheduler.
package uart_pkg;

    localparam int CYCLE_W = 6;
    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        REL,
        DONE,
        GAP
    } state_t;

    // Frame-cycle successor; wraps by compare so any modulus up to 64 works.
    function automatic logic [CYCLE_W-1:0] cycle_next(input logic [CYCLE_W-1:0] cur,
                                                      input int modulus);
        return (int'(cur) == modulus - 1) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/uart_frame_sched_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr, wrapping.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        index = '0;
        cand  = '0;
        // Walk from the farthest candidate back so the nearest one wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NREQ);
            if (req[cand]) begin
                index = cand;
            end
        end
        pick = (|req) ? (NREQ'(1) << index) : '0;
    end

endmodule

// File: rtl/uart_frame_sched.sv
// Round-robin scheduler sharing one RS485 UART frame transmitter between NREQ sources.
// Define FRAME_GAP_EN to insert GAP idle clocks after every frame for bus turnaround.
module uart_frame_sched
    import uart_pkg::*;
#(
    parameter int                 NREQ    = 4,
    parameter int                 CYCLES  = 48,
    parameter logic [TIMER_W-1:0] TIMEOUT = 16'd50000,
    parameter logic [7:0]         GAP     = 8'd32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    output logic [NREQ-1:0]    grant,
    output logic               rq,
    input  logic               full,
    output logic [CYCLE_W-1:0] cycle,
    output logic               done,
    output logic               err,
    output logic               busy
);

    localparam int IDX_W = $clog2(NREQ);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [TIMER_W-1:0] timer;
    logic               err_flag;
    logic               full_m;
    logic               full_s;
    logic [NREQ-1:0]    pick;
    logic [IDX_W-1:0]   pick_idx;

`ifdef FRAME_GAP_EN
    logic [7:0] gap_cnt;
`else
    logic unused_gap;
    assign unused_gap = ^GAP;
`endif

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .index  (pick_idx)
    );

    // full comes from the transmitter's edgeTx domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_m <= 1'b0;
            full_s <= 1'b0;
        end else begin
            full_m <= full;
            full_s <= full_m;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            rq       <= 1'b0;
            cycle    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            timer    <= '0;
            err_flag <= 1'b0;
`ifdef FRAME_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant   <= pick;
                        gnt_idx <= pick_idx;
                        rq      <= 1'b1;
                        busy    <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    timer <= timer + 1'b1;
                    if (full_s) begin
                        rq    <= 1'b0;
                        state <= REL;
                    end else if (timer == TIMEOUT - 1'b1) begin
                        rq       <= 1'b0;
                        err_flag <= 1'b1;
                        state    <= REL;
                    end
                end
                REL: begin
                    if (!full_s) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done     <= 1'b1;
                    err      <= err_flag;
                    grant    <= '0;
                    timer    <= '0;
                    err_flag <= 1'b0;
                    rr_ptr   <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    // A timed-out frame keeps its cycle index so it is retried.
                    if (!err_flag) begin
                        cycle <= cycle_next(cycle, CYCLES);
                    end
`ifdef FRAME_GAP_EN
                    gap_cnt <= '0;
                    state   <= GAP;
`else
                    busy    <= 1'b0;
                    state   <= IDLE;
`endif
                end
                GAP: begin
`ifdef FRAME_GAP_EN
                    if (gap_cnt == GAP - 8'd1) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
`else
                    busy  <= 1'b0;
                    state <= IDLE;
`endif
                end
                default: begin
                    grant <= '0;
                    rq    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Scoreboard bench for uart_frame_sched: random frames against a round-robin reference model.
module tb_uart_frame_sched;

    localparam int NREQ       = 4;
    localparam int CYCLES     = 48;
    localparam int TB_TIMEOUT = 300;
    localparam int TB_GAP     = 32;
`ifdef FRAME_GAP_EN
    localparam int EXP_GAP_DIST = TB_GAP + 1;
`else
    localparam int EXP_GAP_DIST = 1;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] grant;
    logic            rq;
    logic            full = 1'b0;
    logic [5:0]      cycle;
    logic            done;
    logic            err;
    logic            busy;

    uart_frame_sched #(
        .NREQ    (NREQ),
        .CYCLES  (CYCLES),
        .TIMEOUT (16'(TB_TIMEOUT)),
        .GAP     (8'(TB_GAP))
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant),
        .rq    (rq),
        .full  (full),
        .cycle (cycle),
        .done  (done),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model and scoreboard queues.
    typedef struct {
        bit err;
        int cyc;
    } done_t;

    int    exp_grant[$];
    int    exp_rqlen[$];
    done_t exp_done[$];
    int    m_ptr = 0;
    int    m_cycle = 0;

    int tx_delay = 10;
    int tx_clear = 5;
    bit tx_never = 1'b0;
    bit b2b = 1'b0;

    function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Transmitter model: full is raised so the synchronizer first samples it
    // tx_delay clocks after rq rose, which makes rq stay high tx_delay+2 clocks.
    initial begin
        int tx_cnt = 0;
        int tx_clr = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                full = 1'b0;
                tx_cnt = 0;
                tx_clr = 0;
            end else if (rq) begin
                tx_cnt++;
                if (!tx_never && tx_cnt == tx_delay) full = 1'b1;
            end else if (full) begin
                tx_clr++;
                if (tx_clr >= tx_clear) full = 1'b0;
            end else begin
                tx_cnt = 0;
                tx_clr = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant, an rq fall or a done pulse.
    initial begin
        int rq_len = 0;
        int since_fall = 0;
        int gap_dist = 0;
        int gap_busy_low = 0;
        bit gap_armed = 1'b0;
        logic prev_rq = 1'b0;
        logic [NREQ-1:0] prev_grant = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rq_len = 0;
                since_fall = 0;
                gap_armed = 1'b0;
                prev_rq = 1'b0;
                prev_grant = '0;
            end else begin
                if (grant != prev_grant && grant != '0) begin
                    check("grant_onehot", 64'($onehot(grant)), 1);
                    check("rq_with_grant", rq, 1);
                    if (exp_grant.size() == 0) check("grant_unexpected", grant, 0);
                    else begin
                        int w;
                        w = exp_grant.pop_front();
                        check("grant", grant, 64'(1) << w);
                    end
                end
                if (rq) rq_len++;
                else if (prev_rq) begin
                    if (exp_rqlen.size() == 0) check("rq_unexpected", rq_len, 0);
                    else check("rq_high_clks", rq_len, exp_rqlen.pop_front());
                    rq_len = 0;
                    since_fall = 0;
                end else since_fall++;
                if (gap_armed) begin
                    gap_dist++;
                    if (gap_dist < TB_GAP && !busy) gap_busy_low++;
                    if (rq && !prev_rq) begin
                        if (b2b) check("done_to_next_rq", gap_dist, EXP_GAP_DIST);
`ifdef FRAME_GAP_EN
                        if (b2b) check("gap_busy_low", gap_busy_low, 0);
`endif
                        gap_armed = 1'b0;
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) check("done_unexpected", done, 0);
                    else begin
                        done_t e;
                        e = exp_done.pop_front();
                        check("err", err, e.err);
                        check("cycle", cycle, e.cyc);
                        check("grant_at_done", grant, 0);
                        if (e.err) check("rq_fall_to_done", since_fall, 2);
                    end
                    gap_armed = 1'b1;
                    gap_dist = 0;
                    gap_busy_low = busy ? 0 : 1;
                end else if (err) check("err_without_done", err, 0);
                prev_rq = rq;
                prev_grant = grant;
            end
        end
    end

    task automatic issue(input logic [NREQ-1:0] r, input int d, input int clr,
                         input bit never, input bit back);
        int w;
        w = model_pick(r, m_ptr);
        req = r;
        tx_delay = d;
        tx_clear = clr;
        tx_never = never;
        b2b = back;
        exp_grant.push_back(w);
        exp_rqlen.push_back(never ? TB_TIMEOUT : d + 2);
        if (never) exp_done.push_back('{1'b1, m_cycle});
        else begin
            m_cycle = (m_cycle + 1) % CYCLES;
            exp_done.push_back('{1'b0, m_cycle});
        end
        m_ptr = (w + 1) % NREQ;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < budget);
        if (done !== 1'b1) check("done_within_budget", 0, 1);
    endtask

    task automatic frame(input logic [NREQ-1:0] r, input int d, input int clr, input bit never,
                         input bit back, input bit drop, input int budget);
        issue(r, d, clr, never, back);
        if (drop) begin
            int n = 0;
            while (grant == '0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            req = '0;
        end
        wait_done(budget);
    endtask

    task automatic settle();
        req = '0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_grant", grant, 0);
        check("reset_rq", rq, 0);
        check("reset_cycle", cycle, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Contention from rr_ptr=0: 0001, 0010, 1000, 0001.
        frame(4'b1011, 5, 3, 1'b0, 1'b0, 1'b0, 2000);
        for (int i = 0; i < 3; i++) frame(4'b1011, 5, 3, 1'b0, 1'b1, 1'b0, 2000);
        settle();

        // Single long frame.
        frame(4'b0001, 200, 20, 1'b0, 1'b0, 1'b0, 5000);
        settle();

        // Timeout, then the next source gets the following grant.
        frame(4'b1111, 10, 3, 1'b1, 1'b0, 1'b0, 5000);
        frame(4'b1111, 10, 3, 1'b0, 1'b1, 1'b0, 2000);

        // Randomized back-to-back traffic, some sources dropping req mid-frame.
        for (int i = 0; i < 20; i++) begin
            frame(NREQ'($urandom_range(1, 15)), int'($urandom_range(1, 40)),
                  int'($urandom_range(1, 8)), 1'b0, 1'b1, ($urandom_range(0, 3) == 0), 2000);
        end
        settle();

        // Reset while rq is high.
        issue(4'b0100, 100, 5, 1'b0, 1'b0);
        n = 0;
        while (!rq && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rq_before_reset", rq, 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_rq", rq, 0);
        check("midreset_grant", grant, 0);
        check("midreset_busy", busy, 0);
        check("midreset_cycle", cycle, 0);
        exp_done.delete();
        exp_rqlen.delete();
        exp_grant.delete();
        m_ptr = 0;
        m_cycle = 0;
        req = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("postreset_busy", busy, 0);
        frame(4'b1111, 4, 2, 1'b0, 1'b0, 1'b0, 2000);

        // Wrap: 47 more frames take cycle from 1 through 47 and back to 0.
        for (int i = 0; i < 47; i++) begin
            frame(NREQ'($urandom_range(1, 15)), int'($urandom_range(1, 4)),
                  int'($urandom_range(1, 3)), 1'b0, 1'b1, 1'b0, 2000);
        end
        settle();

        check("left_grant", exp_grant.size(), 0);
        check("left_rqlen", exp_rqlen.size(), 0);
        check("left_done", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, expected $finish before 5ms");
        $fatal(1, "watchdog");
    end

endmodule
